// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps every input code of a small combinational
// function, holds each code for DWELL cycles, samples the function output
// into a truth table and compares it with a golden table latched at start.
// Optional build macro TTS_EARLY_ABORT_EN: stop the sweep at the first
// sampled bit that disagrees with the golden table.
`timescale 1ns/1ps

module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int DWELL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN-1:0]        fail_idx
);

  localparam int W     = 1 << N_IN;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  CODE_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   abc_q, abc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      table_q, table_d;
  logic              match_q, match_d;
  logic [N_IN-1:0]   fail_q, fail_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [W-1:0]      tbl_wr;

  // Index of the lowest set bit of v; zero when v has no bits set.
  function automatic logic [N_IN-1:0] lowest_set(input logic [W-1:0] v);
    logic [N_IN-1:0] idx;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) idx = N_IN'(i);
    end
    return idx;
  endfunction

  // State register and all registered outputs; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      match_q <= 1'b0;
      fail_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      exp_q   <= exp_d;
    end
  end

  // Next-state logic: accept start when idle/done, then dwell, sample and step codes.
  always_comb begin
    state_d = state_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    table_d = table_q;
    match_d = match_q;
    fail_d  = fail_q;
    exp_d   = exp_q;
    tbl_wr  = table_q;
    tbl_wr[abc_q] = f_in;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          done_d  = 1'b0;
          match_d = 1'b0;
          fail_d  = '0;
          abc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          table_d = tbl_wr;
`ifdef TTS_EARLY_ABORT_EN
          if (f_in != exp_q[abc_q]) begin
            // Abort at the first disagreeing code; abc_out stays on it.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = 1'b0;
            fail_d  = abc_q;
          end else
`endif
          if (abc_q == CODE_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (tbl_wr == exp_q);
            fail_d  = lowest_set(tbl_wr ^ exp_q);
          end else begin
            abc_d = abc_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign abc_out   = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;
  assign fail_idx  = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with DWELL=2 and one with
// DWELL=1 share clock and reset; the function under test is a lookup table
// held in the bench, so its truth table is known in advance.
`timescale 1ns/1ps

module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start2 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [7:0] func_v = 8'h00;
  bit         sel = 1'b0;

  logic [2:0] abc2, abc1, fidx2, fidx1;
  logic       busy2, busy1, done2, done1, match2, match1;
  logic [7:0] tbl2, tbl1;
  logic       f2, f1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign f2 = func_v[abc2];
  assign f1 = func_v[abc1];

  truth_table_sweeper #(.N_IN(3), .DWELL(2)) u_dw2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected), .f_in(f2),
    .abc_out(abc2), .busy(busy2), .done(done2), .table_out(tbl2),
    .match(match2), .fail_idx(fidx2)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(1)) u_dw1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected), .f_in(f1),
    .abc_out(abc1), .busy(busy1), .done(done1), .table_out(tbl1),
    .match(match1), .fail_idx(fidx1)
  );

  wire [2:0] abc_s   = sel ? abc1   : abc2;
  wire       busy_s  = sel ? busy1  : busy2;
  wire       done_s  = sel ? done1  : done2;
  wire [7:0] tbl_s   = sel ? tbl1   : tbl2;
  wire       match_s = sel ? match1 : match2;
  wire [2:0] fidx_s  = sel ? fidx1  : fidx2;

  typedef struct {
    bit         sel;
    logic [7:0] func;
    logic [7:0] exp;
    bit         disturb;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: what the sweep must report, from the truth table and golden table.
  task automatic model(input logic [7:0] func, input logic [7:0] exp, input int dw,
                       output logic [7:0] tbl, output bit m, output int fidx,
                       output int cyc, output int last);
    int first;
    first = -1;
    for (int k = 0; k < 8; k++)
      if (func[k] != exp[k] && first < 0) first = k;
    m    = (first < 0);
    fidx = m ? 0 : first;
    tbl  = func;
    cyc  = 8 * dw;
    last = 7;
`ifdef TTS_EARLY_ABORT_EN
    if (!m) begin
      tbl  = func & 8'((1 << (first + 1)) - 1);
      cyc  = (first + 1) * dw;
      last = first;
    end
`endif
  endtask

  task automatic sweep(input bit s, input logic [7:0] func, input logic [7:0] exp,
                       input bit disturb, input string tag);
    logic [7:0] m_tbl;
    bit         m_match;
    int         m_fidx, m_cyc, m_last, dw, m;
    sel = s;
    dw  = s ? 1 : 2;
    model(func, exp, dw, m_tbl, m_match, m_fidx, m_cyc, m_last);
    func_v   = func;
    expected = exp;
    if (s) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    check({tag, " busy@start"}, 32'(busy_s), 32'd1);
    check({tag, " done@start"}, 32'(done_s), 32'd0);
    check({tag, " table@start"}, 32'(tbl_s), 32'd0);
    check({tag, " abc@start"}, 32'(abc_s), 32'd0);
    m = 0;
    while (1) begin
      tick();
      m++;
      if (disturb && m == 8) start2 = 1'b0;
      if (done_s) break;
      if (m >= 200) begin
        check({tag, " done timeout"}, 32'(done_s), 32'd1);
        break;
      end
      check({tag, " abc step"}, 32'(abc_s), 32'(m / dw));
      check({tag, " busy step"}, 32'(busy_s), 32'd1);
      if (disturb && m == 7) begin
        start2   = 1'b1;
        expected = ~exp;
      end
    end
    start1 = 1'b0;
    start2 = 1'b0;
    check({tag, " done cycle"}, 32'(m), 32'(m_cyc));
    check({tag, " table"}, 32'(tbl_s), 32'(m_tbl));
    check({tag, " match"}, 32'(match_s), 32'(m_match));
    check({tag, " fail_idx"}, 32'(fidx_s), 32'(m_fidx));
    check({tag, " busy@done"}, 32'(busy_s), 32'd0);
    check({tag, " abc@done"}, 32'(abc_s), 32'(m_last));
    expected = exp;
    repeat (3) tick();
    check({tag, " done hold"}, 32'(done_s), 32'd1);
    check({tag, " table hold"}, 32'(tbl_s), 32'(m_tbl));
    check({tag, " match hold"}, 32'(match_s), 32'(m_match));
  endtask

  initial begin
    logic [7:0] rf, re;
    bit         rs;

    vecs[0] = '{1'b0, 8'hBB, 8'hBB, 1'b0};
    vecs[1] = '{1'b0, 8'hBB, 8'hBF, 1'b0};
    vecs[2] = '{1'b0, 8'hBB, 8'hBB, 1'b1};
    vecs[3] = '{1'b1, 8'hBB, 8'hBB, 1'b0};
    vecs[4] = '{1'b1, 8'hBB, 8'hBB, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h80, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 8'hFE, 1'b0};

    // Reset, then idle.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst abc", 32'(abc2), 32'd0);
    check("rst busy", 32'(busy2), 32'd0);
    check("rst done", 32'(done2), 32'd0);
    check("rst table", 32'(tbl2), 32'd0);
    check("rst match", 32'(match2), 32'd0);
    check("rst fail_idx", 32'(fidx2), 32'd0);
    check("rst busy dw1", 32'(busy1), 32'd0);

    for (int i = 0; i < 7; i++)
      sweep(vecs[i].sel, vecs[i].func, vecs[i].exp, vecs[i].disturb, $sformatf("vec%0d", i));

    // Reset in the middle of a sweep discards it.
    sel = 1'b0;
    func_v = 8'hBB;
    expected = 8'hBB;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (9) tick();
    check("midrst busy before", 32'(busy2), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst busy", 32'(busy2), 32'd0);
    check("midrst done", 32'(done2), 32'd0);
    check("midrst table", 32'(tbl2), 32'd0);
    check("midrst abc", 32'(abc2), 32'd0);
    rst_n = 1'b1;
    tick();
    sweep(1'b0, 8'hBB, 8'hBB, 1'b0, "after_midrst");

    // Reset and start on the same edge: reset wins.
    rst_n = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    rst_n = 1'b1;
    check("rst+start busy", 32'(busy2), 32'd0);
    check("rst+start done", 32'(done2), 32'd0);
    tick();
    check("rst+start idle", 32'(busy2), 32'd0);

    // Randomized sweeps against the reference.
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      rf = 8'($urandom);
      re = ($urandom_range(0, 1) == 0) ? rf : 8'($urandom);
      sweep(rs, rf, re, 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
